// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Shares the single-port data memory between the CPU memory stage and the LCD
// reader. One access is in flight at a time. The CPU has priority, but the
// LCD is guaranteed a slot after STARVE_LIMIT consecutive CPU wins while it
// waits.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   cpu_req/we/addr/wdata         CPU request (level, held until serviced)
//   cpu_gnt, cpu_rvalid           one-cycle pulses: issued / read data valid
//   cpu_rdata                     CPU read data, held until the next CPU read
//   cpu_stall                     CPU must not advance (combinational)
//   lcd_req/addr                  LCD read request (level)
//   lcd_gnt, lcd_rvalid, lcd_rdata  LCD counterparts of the CPU outputs
//   mem_addr/wdata/rd_en/wr_en    registered memory command
//   mem_rdata                     memory data, valid RD_LATENCY cycles after rd_en
module dmem_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int RD_LATENCY   = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_gnt,
  output logic                  cpu_rvalid,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_stall,
  input  logic                  lcd_req,
  input  logic [ADDR_WIDTH-1:0] lcd_addr,
  output logic                  lcd_gnt,
  output logic                  lcd_rvalid,
  output logic [DATA_WIDTH-1:0] lcd_rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_rd_en,
  output logic                  mem_wr_en,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam logic [2:0] LAT  = 3'(RD_LATENCY);
  localparam logic [3:0] SLIM = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t      state, state_nxt;
  logic        own_lcd;     // owner of the access in flight
  logic        we_q;        // latched write flag of the access in flight
  logic [2:0]  wait_cnt;
  logic [3:0]  starve_cnt;
  logic        arb_pt, any_req, lcd_win, rd_done;

  // IDLE and RESP are both arbitration points, so back-to-back accesses
  // need no idle bubble.
  assign arb_pt  = (state == IDLE) || (state == RESP);
  assign any_req = cpu_req | lcd_req;
  assign lcd_win = lcd_req & (~cpu_req | (starve_cnt == SLIM));
  assign rd_done = (state == WAIT) && (wait_cnt == LAT);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, RESP: state_nxt = any_req ? ISSUE : IDLE;
      ISSUE:      state_nxt = we_q ? IDLE : WAIT;
      WAIT:       if (wait_cnt == LAT) state_nxt = RESP;
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      own_lcd    <= 1'b0;
      we_q       <= 1'b0;
      wait_cnt   <= '0;
      starve_cnt <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_rd_en  <= 1'b0;
      mem_wr_en  <= 1'b0;
      cpu_rdata  <= '0;
      lcd_rdata  <= '0;
    end else begin
      // Enables are loaded at the arbitration edge so they are high exactly
      // during ISSUE; every other edge clears them.
      mem_rd_en <= 1'b0;
      mem_wr_en <= 1'b0;
      if (arb_pt && any_req) begin
        own_lcd   <= lcd_win;
        we_q      <= ~lcd_win & cpu_we;
        mem_addr  <= lcd_win ? lcd_addr : cpu_addr;
        if (!lcd_win) mem_wdata <= cpu_wdata;
        mem_rd_en <= lcd_win | ~cpu_we;
        mem_wr_en <= ~lcd_win & cpu_we;
      end

      // Counts CPU wins that pushed a waiting LCD back; any point where the
      // LCD is not waiting, or wins, resets the guarantee window.
      if (arb_pt) begin
        if (!lcd_req || lcd_win)     starve_cnt <= '0;
        else if (starve_cnt != 4'hF) starve_cnt <= starve_cnt + 4'd1;
      end

      if (state == ISSUE)     wait_cnt <= 3'd1;
      else if (state == WAIT) wait_cnt <= wait_cnt + 3'd1;

      if (rd_done) begin
        if (own_lcd) lcd_rdata <= mem_rdata;
        else         cpu_rdata <= mem_rdata;
      end
    end
  end

  assign cpu_gnt    = (state == ISSUE) && !own_lcd;
  assign lcd_gnt    = (state == ISSUE) &&  own_lcd;
  assign cpu_rvalid = (state == RESP)  && !own_lcd;
  assign lcd_rvalid = (state == RESP)  &&  own_lcd;

  // Writes release the CPU at grant, reads at data return.
  assign cpu_stall = cpu_req & ~(cpu_gnt & cpu_we) & ~cpu_rvalid;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter. Two instances share the requester inputs:
// "a" uses RD_LATENCY=1, "b" uses RD_LATENCY=3. Each has its own memory model
// whose read data is a fixed function of the address.
module tb_dmem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cpu_req = 1'b0, cpu_we = 1'b0, lcd_req = 1'b0;
  logic [AW-1:0] cpu_addr = '0, lcd_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;

  logic          a_cpu_gnt, a_cpu_rvalid, a_cpu_stall, a_lcd_gnt, a_lcd_rvalid;
  logic          a_mem_rd_en, a_mem_wr_en;
  logic [DW-1:0] a_cpu_rdata, a_lcd_rdata, a_mem_wdata, a_mem_rdata;
  logic [AW-1:0] a_mem_addr;
  logic          b_cpu_gnt, b_cpu_rvalid, b_cpu_stall, b_lcd_gnt, b_lcd_rvalid;
  logic          b_mem_rd_en, b_mem_wr_en;
  logic [DW-1:0] b_cpu_rdata, b_lcd_rdata, b_mem_wdata, b_mem_rdata;
  logic [AW-1:0] b_mem_addr;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(1), .STARVE_LIMIT(4)) dut_a (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(a_cpu_gnt), .cpu_rvalid(a_cpu_rvalid), .cpu_rdata(a_cpu_rdata), .cpu_stall(a_cpu_stall),
    .lcd_req(lcd_req), .lcd_addr(lcd_addr),
    .lcd_gnt(a_lcd_gnt), .lcd_rvalid(a_lcd_rvalid), .lcd_rdata(a_lcd_rdata),
    .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_rd_en(a_mem_rd_en),
    .mem_wr_en(a_mem_wr_en), .mem_rdata(a_mem_rdata));

  dmem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(3), .STARVE_LIMIT(4)) dut_b (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(b_cpu_gnt), .cpu_rvalid(b_cpu_rvalid), .cpu_rdata(b_cpu_rdata), .cpu_stall(b_cpu_stall),
    .lcd_req(lcd_req), .lcd_addr(lcd_addr),
    .lcd_gnt(b_lcd_gnt), .lcd_rvalid(b_lcd_rvalid), .lcd_rdata(b_lcd_rdata),
    .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_rd_en(b_mem_rd_en),
    .mem_wr_en(b_mem_wr_en), .mem_rdata(b_mem_rdata));

  function automatic logic [DW-1:0] rd_fn(input logic [AW-1:0] addr);
    case (addr)
      32'h10:  rd_fn = 32'hDEADBEEF;
      32'h18:  rd_fn = 32'h5555AAAA;
      32'h40:  rd_fn = 32'h00004040;
      32'h44:  rd_fn = 32'h00004444;
      default: rd_fn = 32'hA5A50000 | {16'h0, addr[15:0]};
    endcase
  endfunction

  // Memory models: junk data unless a read was sampled the right number of
  // edges earlier, so a latency error shows up as wrong data.
  logic [DW-1:0] a_pipe = '0;
  logic [DW-1:0] b_pipe0 = '0, b_pipe1 = '0, b_pipe2 = '0;
  int            a_wcnt = 0;
  logic [AW-1:0] a_waddr = '0;
  logic [DW-1:0] a_wdat = '0;

  always @(posedge clk) begin
    a_pipe  <= a_mem_rd_en ? rd_fn(a_mem_addr) : 32'h0BAD0BAD;
    b_pipe0 <= b_mem_rd_en ? rd_fn(b_mem_addr) : 32'h0BAD0BAD;
    b_pipe1 <= b_pipe0;
    b_pipe2 <= b_pipe1;
    if (a_mem_wr_en) begin
      a_wcnt  <= a_wcnt + 1;
      a_waddr <= a_mem_addr;
      a_wdat  <= a_mem_wdata;
    end
  end
  assign a_mem_rdata = a_pipe;
  assign b_mem_rdata = b_pipe2;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Start of a new cycle (inputs driven here are sampled at its end).
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic chk_reset_a();
    chk1 ("rst_cpu_gnt",    a_cpu_gnt,    1'b0);
    chk1 ("rst_cpu_rvalid", a_cpu_rvalid, 1'b0);
    chk1 ("rst_lcd_gnt",    a_lcd_gnt,    1'b0);
    chk1 ("rst_lcd_rvalid", a_lcd_rvalid, 1'b0);
    chk1 ("rst_rd_en",      a_mem_rd_en,  1'b0);
    chk1 ("rst_wr_en",      a_mem_wr_en,  1'b0);
    chk32("rst_mem_addr",   a_mem_addr,   32'h0);
    chk32("rst_mem_wdata",  a_mem_wdata,  32'h0);
    chk32("rst_cpu_rdata",  a_cpu_rdata,  32'h0);
    chk32("rst_lcd_rdata",  a_lcd_rdata,  32'h0);
    chk1 ("rst_b_cpu_rvalid", b_cpu_rvalid, 1'b0);
    chk1 ("rst_b_rd_en",      b_mem_rd_en,  1'b0);
    chk32("rst_b_mem_addr",   b_mem_addr,   32'h0);
  endtask

  // One read on the RD_LATENCY=3 instance: request in c0, grant in c1,
  // nothing at c4, rvalid in c5 (five cycles after the request).
  task automatic rd3(input logic lcd, input logic [31:0] addr,
                     input logic [31:0] exp, input logic [31:0] other);
    cyc();
    if (lcd) begin lcd_req = 1'b1; lcd_addr = addr; end
    else begin cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = addr; end
    cyc(); mid();
    chk1("l3_gnt", lcd ? b_lcd_gnt : b_cpu_gnt, 1'b1);
    chk1("l3_rd_en", b_mem_rd_en, 1'b1);
    lcd_req = 1'b0; cpu_req = 1'b0;
    cyc(); cyc(); cyc(); mid();
    chk1("l3_early_rvalid", b_cpu_rvalid | b_lcd_rvalid, 1'b0);
    cyc(); mid();
    chk1 ("l3_rvalid",       lcd ? b_lcd_rvalid : b_cpu_rvalid, 1'b1);
    chk1 ("l3_other_rvalid", lcd ? b_cpu_rvalid : b_lcd_rvalid, 1'b0);
    chk32("l3_rdata",        lcd ? b_lcd_rdata  : b_cpu_rdata,  exp);
    chk32("l3_other_held",   lcd ? b_cpu_rdata  : b_lcd_rdata,  other);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] lcd_turn;
    logic       lw;
    int         w0;

    // Reset state
    cyc(); cyc(); mid();
    chk_reset_a();
    chk1("rst_stall", a_cpu_stall, 1'b0);
    cyc(); rst = 1'b0;

    // CPU read, stall held until rvalid
    cyc(); cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10; mid();
    chk1("rd_stall_c0", a_cpu_stall, 1'b1);
    chk1("rd_gnt_c0",   a_cpu_gnt,   1'b0);
    cyc(); mid();
    chk1 ("rd_gnt",      a_cpu_gnt,   1'b1);
    chk1 ("rd_rd_en",    a_mem_rd_en, 1'b1);
    chk1 ("rd_wr_en",    a_mem_wr_en, 1'b0);
    chk32("rd_mem_addr", a_mem_addr,  32'h10);
    chk1 ("rd_stall_c1", a_cpu_stall, 1'b1);
    cyc(); mid();
    chk1("rd_gnt_c2",    a_cpu_gnt,    1'b0);
    chk1("rd_rd_en_c2",  a_mem_rd_en,  1'b0);
    chk1("rd_rvalid_c2", a_cpu_rvalid, 1'b0);
    chk1("rd_stall_c2",  a_cpu_stall,  1'b1);
    cyc(); mid();
    chk1 ("rd_rvalid",     a_cpu_rvalid, 1'b1);
    chk32("rd_rdata",      a_cpu_rdata,  32'hDEADBEEF);
    chk1 ("rd_stall_c3",   a_cpu_stall,  1'b0);
    chk1 ("rd_lcd_rvalid", a_lcd_rvalid, 1'b0);
    cpu_req = 1'b0;
    cyc(); mid();
    chk1 ("rd_rvalid_c4", a_cpu_rvalid, 1'b0);
    chk32("rd_rdata_held", a_cpu_rdata, 32'hDEADBEEF);
    cyc(); mid();
    chk1 ("rd_l3_rvalid", b_cpu_rvalid, 1'b1);
    chk32("rd_l3_rdata",  b_cpu_rdata,  32'hDEADBEEF);
    cyc();

    // CPU write
    w0 = a_wcnt;
    cyc(); cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h20; cpu_wdata = 32'h12345678; mid();
    chk1("wr_stall_c0", a_cpu_stall, 1'b1);
    chk1("wr_wr_en_c0", a_mem_wr_en, 1'b0);
    cyc(); mid();
    chk1 ("wr_gnt",       a_cpu_gnt,   1'b1);
    chk1 ("wr_wr_en",     a_mem_wr_en, 1'b1);
    chk1 ("wr_rd_en",     a_mem_rd_en, 1'b0);
    chk32("wr_mem_addr",  a_mem_addr,  32'h20);
    chk32("wr_mem_wdata", a_mem_wdata, 32'h12345678);
    chk1 ("wr_stall_gnt", a_cpu_stall, 1'b0);
    cpu_req = 1'b0;
    cyc(); mid();
    chk1 ("wr_wr_en_c2",  a_mem_wr_en,  1'b0);
    chk1 ("wr_gnt_c2",    a_cpu_gnt,    1'b0);
    chk1 ("wr_rvalid_c2", a_cpu_rvalid, 1'b0);
    chk32("wr_addr_hold", a_mem_addr,   32'h20);
    chk32("wr_count",     a_wcnt,       w0 + 1);
    chk32("wr_addr_seen", a_waddr,      32'h20);
    chk32("wr_data_seen", a_wdat,       32'h12345678);
    cyc(); mid();
    chk1("wr_rvalid_c3", a_cpu_rvalid, 1'b0);
    chk1("wr_wr_en_c3",  a_mem_wr_en,  1'b0);

    // Reset for two cycles while a read is in WAIT
    cyc(); cpu_we = 1'b0; cpu_req = 1'b1; cpu_addr = 32'h30;
    cyc(); mid();
    chk1("rr_gnt", a_cpu_gnt, 1'b1);
    cpu_req = 1'b0;
    cyc(); rst = 1'b1;
    cyc(); mid();
    chk_reset_a();
    cyc(); rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      mid();
      chk1("rr_no_cpu_rvalid",   a_cpu_rvalid | b_cpu_rvalid, 1'b0);
      chk1("rr_no_lcd_rvalid",   a_lcd_rvalid | b_lcd_rvalid, 1'b0);
      cyc();
    end
    cpu_req = 1'b1; cpu_addr = 32'h10;
    cyc(); mid();
    chk1("rr_next_gnt", a_cpu_gnt, 1'b1);
    cpu_req = 1'b0;
    cyc(); cyc(); mid();
    chk1 ("rr_next_rvalid", a_cpu_rvalid, 1'b1);
    chk32("rr_next_rdata",  a_cpu_rdata,  32'hDEADBEEF);
    cyc(); cyc();

    // Starvation guard: both requests held
    lcd_turn = 10'b1000010000;
    cyc(); cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h18; lcd_req = 1'b1; lcd_addr = 32'h40;
    for (int g = 0; g < 10; g++) begin
      lw = lcd_turn[g];
      cyc(); mid();
      chk1("sv_cpu_gnt", a_cpu_gnt,   ~lw);
      chk1("sv_lcd_gnt", a_lcd_gnt,   lw);
      chk1("sv_stall",   a_cpu_stall, 1'b1);
      cyc();
      cyc(); mid();
      chk1 ("sv_cpu_rvalid", a_cpu_rvalid, ~lw);
      chk1 ("sv_lcd_rvalid", a_lcd_rvalid, lw);
      chk32("sv_cpu_rdata",  a_cpu_rdata,  32'h5555AAAA);
      chk32("sv_lcd_rdata",  a_lcd_rdata,  (g >= 4) ? 32'h00004040 : 32'h0);
      chk1 ("sv_stall_resp", a_cpu_stall,  lw);
    end
    cpu_req = 1'b0; lcd_req = 1'b0;
    cyc(); cyc();

    // Latency sweep on the RD_LATENCY=3 instance
    rst = 1'b1;
    cyc(); cyc(); rst = 1'b0;
    rd3(1'b1, 32'h40, 32'h00004040, 32'h0);
    rd3(1'b0, 32'h10, 32'hDEADBEEF, 32'h00004040);
    rd3(1'b1, 32'h44, 32'h00004444, 32'hDEADBEEF);
    rd3(1'b0, 32'h18, 32'h5555AAAA, 32'h00004444);

    // Simultaneous requests with an empty starvation count
    cyc(); cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h18; lcd_req = 1'b1; lcd_addr = 32'h40;
    cyc(); mid();
    chk1("sim_cpu_gnt", a_cpu_gnt, 1'b1);
    chk1("sim_lcd_gnt", a_lcd_gnt, 1'b0);
    cpu_req = 1'b0;
    cyc(); cyc(); mid();
    chk1("sim_cpu_rvalid", a_cpu_rvalid, 1'b1);
    cyc(); mid();
    chk1("sim_lcd_gnt2",   a_lcd_gnt, 1'b1);
    chk1("sim_cpu_gnt2",   a_cpu_gnt, 1'b0);
    lcd_req = 1'b0;
    cyc(); cyc(); mid();
    chk1 ("sim_lcd_rvalid", a_lcd_rvalid, 1'b1);
    chk32("sim_lcd_rdata",  a_lcd_rdata,  32'h00004040);
    chk32("sim_cpu_rdata",  a_cpu_rdata,  32'h5555AAAA);
    cyc(); cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
